// File: rtl/sel_rr_pipe.sv
// CHANNELS-way registered selector with valid/ready handshake: fixed select or round-robin arbitration.
// Optional SEL_RR_PIPE_STALL_CNT_EN adds a saturating 16-bit stall counter on oStall.
module sel_rr_pipe #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] iC,
    input  logic [CHANNELS-1:0]       iValid,
    output logic [CHANNELS-1:0]       oReady,
    input  logic                      iMode,
    input  logic [SEL_W-1:0]          iS,
    output logic [WIDTH-1:0]          oZ,
    output logic [SEL_W-1:0]          oSel,
    output logic                      oValid,
    input  logic                      iReady
`ifdef SEL_RR_PIPE_STALL_CNT_EN
   ,output logic [15:0]               oStall
`endif
);

    logic [WIDTH-1:0] oz_q, oz_d;
    logic [SEL_W-1:0] osel_q, osel_d;
    logic             ovalid_q, ovalid_d;
    logic [SEL_W-1:0] last_q, last_d;

    logic [SEL_W-1:0] cand;
    logic             cand_vld;
    logic             can_load;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;
    int               idx;

    // Round-robin search starts one past the last granted channel and wraps.
    always_comb begin
        cand     = '0;
        cand_vld = 1'b0;
        idx      = 0;
        if (!iMode) begin
            if (int'(iS) < CHANNELS) begin
                cand     = iS;
                cand_vld = 1'b1;
            end
        end else begin
            for (int i = 1; i <= CHANNELS; i++) begin
                idx = (int'(last_q) + i) % CHANNELS;
                if (!cand_vld && iValid[idx]) begin
                    cand     = SEL_W'(idx);
                    cand_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (cand == SEL_W'(k)) begin
                sel_data = iC[k*WIDTH +: WIDTH];
            end
        end
    end

    assign can_load = !ovalid_q || iReady;
    assign oReady   = (can_load && cand_vld) ? (CHANNELS'(1) << cand) : '0;
    assign xfer     = |(oReady & iValid);

    always_comb begin
        oz_d     = oz_q;
        osel_d   = osel_q;
        ovalid_d = ovalid_q;
        last_d   = last_q;
        if (xfer) begin
            oz_d     = sel_data;
            osel_d   = cand;
            ovalid_d = 1'b1;
            if (iMode) begin
                last_d = cand;
            end
        end else if (ovalid_q && iReady) begin
            ovalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oz_q     <= '0;
            osel_q   <= '0;
            ovalid_q <= 1'b0;
            last_q   <= SEL_W'(CHANNELS - 1);
        end else begin
            oz_q     <= oz_d;
            osel_q   <= osel_d;
            ovalid_q <= ovalid_d;
            last_q   <= last_d;
        end
    end

    assign oZ     = oz_q;
    assign oSel   = osel_q;
    assign oValid = ovalid_q;

`ifdef SEL_RR_PIPE_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Any accepted word clears the count; otherwise a held word counts up and saturates.
    always_comb begin
        stall_d = stall_q;
        if (ovalid_q && iReady) begin
            stall_d = '0;
        end else if (ovalid_q && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign oStall = stall_q;
`endif

endmodule

// File: tb/tb_sel_rr_pipe.sv
// Self-checking bench for sel_rr_pipe: directed scenarios plus randomized traffic against a behavioural model.
module tb_sel_rr_pipe;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] iC = '0;
    logic [7:0]   iValid = '0;
    logic [7:0]   oReady;
    logic         iMode = 1'b0;
    logic [2:0]   iS = '0;
    logic [31:0]  oZ;
    logic [2:0]   oSel;
    logic         oValid;
    logic         iReady = 1'b0;

    logic [5:0]   iValid6 = '0;
    logic [5:0]   oReady6;
    logic         iMode6 = 1'b0;
    logic [2:0]   iS6 = '0;
    logic [31:0]  oZ6;
    logic [2:0]   oSel6;
    logic         oValid6;
    logic         iReady6 = 1'b1;
`ifdef SEL_RR_PIPE_STALL_CNT_EN
    logic [15:0]  oStall;
    logic [15:0]  oStall6;
`endif

    int errors = 0;
    int checks = 0;

    // Model state
    bit          m_valid;
    logic [31:0] m_z;
    int          m_sel;
    int          m_last;
    int          m_stall;

    always #5 clk = ~clk;

    sel_rr_pipe #(.WIDTH(32), .CHANNELS(8), .SEL_W(3)) dut (
        .clk(clk), .rst(rst), .iC(iC), .iValid(iValid), .oReady(oReady),
        .iMode(iMode), .iS(iS), .oZ(oZ), .oSel(oSel), .oValid(oValid),
        .iReady(iReady)
`ifdef SEL_RR_PIPE_STALL_CNT_EN
       ,.oStall(oStall)
`endif
    );

    sel_rr_pipe #(.WIDTH(32), .CHANNELS(6), .SEL_W(3)) dut6 (
        .clk(clk), .rst(rst), .iC(iC[191:0]), .iValid(iValid6), .oReady(oReady6),
        .iMode(iMode6), .iS(iS6), .oZ(oZ6), .oSel(oSel6), .oValid(oValid6),
        .iReady(iReady6)
`ifdef SEL_RR_PIPE_STALL_CNT_EN
       ,.oStall(oStall6)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lane(input int k);
        return iC[k*32 +: 32];
    endfunction

    task automatic set_lane(input int k, input logic [31:0] v);
        iC[k*32 +: 32] = v;
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_z     = '0;
        m_sel   = 0;
        m_last  = 7;
        m_stall = 0;
    endtask

    function automatic int pick(input bit mode, input int sel, input logic [7:0] v, input int last);
        if (!mode) return (sel < 8) ? sel : -1;
        for (int k = 1; k <= 8; k++) begin
            if (v[(last + k) % 8]) return (last + k) % 8;
        end
        return -1;
    endfunction

    // One clock: compare DUT against the model before the edge, then advance the model across it.
    task automatic step();
        int          c;
        bit          load_ok;
        bit          xfer;
        logic [7:0]  exp_ready;
        @(negedge clk);
        c         = pick(iMode, int'(iS), iValid, m_last);
        load_ok   = !m_valid || iReady;
        exp_ready = (load_ok && c >= 0) ? 8'(1 << c) : 8'h00;
        xfer      = load_ok && c >= 0 && iValid[c];
        check("model_oReady", 64'(oReady), 64'(exp_ready));
        check("model_oValid", 64'(oValid), 64'(m_valid));
        check("model_oZ", 64'(oZ), 64'(m_z));
        check("model_oSel", 64'(oSel), 64'(m_sel));
`ifdef SEL_RR_PIPE_STALL_CNT_EN
        check("model_oStall", 64'(oStall), 64'(m_stall));
`endif
        @(posedge clk);
        if (m_valid && iReady) m_stall = 0;
        else if (m_valid && m_stall < 65535) m_stall = m_stall + 1;
        if (xfer) begin
            m_z     = lane(c);
            m_sel   = c;
            m_valid = 1;
            if (iMode) m_last = c;
        end else if (m_valid && iReady) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #1;
        check("reset_oValid", 64'(oValid), 64'h0);
        check("reset_oZ", 64'(oZ), 64'h0);
        check("reset_oSel", 64'(oSel), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fixed mode, channel 2
        iMode = 0; iS = 3'd2; iValid = 8'h04; iReady = 1;
        set_lane(2, 32'hDEADBEEF);
        #1;
        check("fixed_oReady", 64'(oReady), 64'h04);
        step();
        check("fixed_oZ", 64'(oZ), 64'hDEADBEEF);
        check("fixed_oSel", 64'(oSel), 64'd2);
        check("fixed_oValid", 64'(oValid), 64'd1);

        // Round-robin fairness from reset
        do_reset();
        for (int k = 0; k < 8; k++) set_lane(k, 32'hA000_0000 + 32'(k));
        iMode = 1; iValid = 8'hFF; iReady = 1;
        for (int i = 0; i < 9; i++) begin
            step();
            check("rr_fair_oSel", 64'(oSel), 64'(i % 8));
            check("rr_fair_oValid", 64'(oValid), 64'd1);
        end

        // Skip and wrap with last=1
        do_reset();
        iValid = 8'h02;
        step();
        check("rr_seed_oSel", 64'(oSel), 64'd1);
        iValid = 8'h82;
        step();
        check("rr_wrap_a", 64'(oSel), 64'd7);
        step();
        check("rr_wrap_b", 64'(oSel), 64'd1);
        step();
        check("rr_wrap_c", 64'(oSel), 64'd7);

        // Back-pressure
        iMode = 0; iS = 3'd0; iValid = 8'h01; iReady = 1;
        set_lane(0, 32'h12345678);
        step();
        check("bp_load_oZ", 64'(oZ), 64'h12345678);
        iReady = 0;
        for (int i = 0; i < 5; i++) begin
            iMode  = 1'($urandom_range(0, 1));
            iS     = 3'($urandom_range(0, 7));
            iValid = 8'($urandom);
            for (int k = 0; k < 8; k++) set_lane(k, $urandom);
            #1;
            check("bp_oReady", 64'(oReady), 64'h0);
            step();
            check("bp_oZ", 64'(oZ), 64'h12345678);
            check("bp_oSel", 64'(oSel), 64'd0);
            check("bp_oValid", 64'(oValid), 64'd1);
        end
`ifdef SEL_RR_PIPE_STALL_CNT_EN
        check("stall_count5", 64'(oStall), 64'd5);
`endif
        iReady = 1; iMode = 0; iS = 3'd3; iValid = 8'h08;
        set_lane(3, 32'hCAFEF00D);
        #1;
        check("bp_release_oReady", 64'(oReady), 64'h08);
        step();
        check("bp_release_oZ", 64'(oZ), 64'hCAFEF00D);
        check("bp_release_oValid", 64'(oValid), 64'd1);
`ifdef SEL_RR_PIPE_STALL_CNT_EN
        check("stall_clear", 64'(oStall), 64'd0);
`endif

        // Reset asserted mid-stall takes effect without a clock edge
        iReady = 0;
        step();
        step();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_oValid", 64'(oValid), 64'd0);
        check("midrst_oZ", 64'(oZ), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifdef SEL_RR_PIPE_STALL_CNT_EN
        iMode = 0; iS = 3'd1; iValid = 8'h02; iReady = 1;
        step();
        iReady = 0;
        for (int i = 0; i < 70000; i++) step();
        check("stall_saturate", 64'(oStall), 64'hFFFF);
        do_reset();
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            iMode  = 1'($urandom_range(0, 1));
            iS     = 3'($urandom_range(0, 7));
            iValid = 8'($urandom);
            iReady = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 8; k++) set_lane(k, $urandom);
            step();
        end

        // 6-channel instance: out-of-range select, fixed select, round-robin wrap
        iC = '0;
        set_lane(0, 32'hC0DE0000);
        set_lane(5, 32'hC0DE0005);
        iMode6 = 0; iS6 = 3'd7; iValid6 = 6'h3F; iReady6 = 1;
        #1;
        check("ch6_oor_oReady", 64'(oReady6), 64'h0);
        @(posedge clk);
        #1;
        check("ch6_oor_oValid", 64'(oValid6), 64'd0);
        iS6 = 3'd5;
        #1;
        check("ch6_fixed_oReady", 64'(oReady6), 64'h20);
        @(posedge clk);
        #1;
        check("ch6_fixed_oSel", 64'(oSel6), 64'd5);
        check("ch6_fixed_oZ", 64'(oZ6), 64'hC0DE0005);
        iMode6 = 1; iValid6 = 6'h21;
        @(posedge clk);
        #1;
        check("ch6_rr_a", 64'(oSel6), 64'd0);
        check("ch6_rr_a_oZ", 64'(oZ6), 64'hC0DE0000);
        @(posedge clk);
        #1;
        check("ch6_rr_b", 64'(oSel6), 64'd5);
        @(posedge clk);
        #1;
        check("ch6_rr_c", 64'(oSel6), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sel_rr_pipe.md
Name: sel_rr_pipe

Overview:
- Parametrised successor to the datapath selectors: CHANNELS-way, WIDTH-bit selector with a registered output stage and a valid/ready handshake.
- Two modes: fixed binary select, as in the existing selectors, or round-robin arbitration among valid channels.
- Sits between multicycle-CPU operand sources (regfile, ALU, memory, immediate) and shared consumers (ALU input latch, memory write port).
- Output is registered, so selection no longer adds to the source-to-consumer combinational path.

Parameters:
- WIDTH, 32, data width per channel.
- CHANNELS, 8, number of input channels (2..16).
- SEL_W, 3, select width; must equal clog2(CHANNELS).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- iC  input  CHANNELS*WIDTH  channel data, flattened; channel k = bits [k*WIDTH +: WIDTH].
- iValid  input  CHANNELS  per-channel data valid.
- oReady  output  CHANNELS  per-channel accept; at most one bit high.
- iMode  input  1  0 = fixed select, 1 = round-robin.
- iS  input  SEL_W  fixed-mode channel select.
- oZ  output  WIDTH  registered selected data.
- oSel  output  SEL_W  channel index that produced oZ.
- oValid  output  1  oZ/oSel hold a valid word.
- iReady  input  1  downstream accepts the word.

Behaviour:
- Reset (async, immediate): oValid=0, oZ=0, oSel=0; round-robin pointer last=CHANNELS-1, so channel 0 has first priority.
- Output register is one entry. can_load = !oValid || iReady, evaluated combinationally.
- Candidate, fixed mode: c = iS. If iS >= CHANNELS, there is no candidate and all oReady=0.
- Candidate, round-robin mode: c = first k with iValid[k]=1, searching last+1, last+2, … with modulo-CHANNELS wrap. No valid bit set means no candidate.
- Grant: oReady[c] = can_load && candidate exists. All other oReady bits are 0.
- Transfer occurs when oReady[c] && iValid[c]. On that clock edge: oZ<=iC[c], oSel<=c, oValid<=1.
- Pointer update: last<=c on a transfer, in round-robin mode only.
- Fixed mode never modifies last. Switching modes keeps last.
- Latency: one cycle from accepted input to oValid.
- Throughput: one word per cycle when iReady is held high.
- Drain: oValid && iReady with no transfer that cycle gives oValid<=0 next edge; oZ and oSel retain their old values.
- Stall: while oValid && !iReady, oZ, oSel and oValid are held stable and all oReady=0.
- Simultaneous drain and load: when iReady=1 and a new transfer both occur, the register is overwritten and oValid stays 1. No bubble.
- Fixed mode with the selected channel invalid: oReady[iS] may be 1, no transfer occurs, and the register drains normally.
- iMode and iS are sampled every cycle. A change takes effect in the same cycle's grant and never disturbs a held word.
- Round-robin wrap: with last=CHANNELS-1, the search starts at channel 0.
- Single-requester case: the same channel is granted every cycle.
- Reset asserted mid-stall: the held word is discarded and oValid drops immediately, asynchronously.

Optional Feature:
- Macro: SEL_RR_PIPE_STALL_CNT_EN.
- Defined: adds output oStall (16 bits) and a counter that increments each cycle oValid && !iReady.
  - The counter saturates at 16'hFFFF.
  - It resets to 0 on rst, or on any cycle with oValid && iReady.
  - oStall is the registered counter value.
- Undefined: no oStall port and no counter. Behaviour is otherwise identical.

Test Plan:
- Fixed mode: iMode=0, iS=2, iValid=8'h04, iC ch2=32'hDEADBEEF, iReady=1 -> oReady=8'h04; next cycle oZ=32'hDEADBEEF, oSel=2, oValid=1.
- Round-robin fairness: iMode=1, iValid=8'hFF held, iReady=1 after reset -> oSel sequence 0,1,…,7,0 with one word per cycle and no bubbles.
- Round-robin skip/wrap: iMode=1, iValid=8'b1000_0010, last=1 -> grant 7, then 1, then 7.
- Back-pressure: oValid=1 with oZ=32'h12345678, iReady=0 for 5 cycles while inputs change -> oZ, oSel stable and oReady=0 throughout; iReady=1 -> the next word is loaded in the same cycle.
- Out-of-range and mid-reset: CHANNELS=6, SEL_W=3, iS=7 -> oReady=0 and no transfer; assert rst while stalled -> oValid=0, oZ=0 with no clock edge required.
- With SEL_RR_PIPE_STALL_CNT_EN: 3 stall cycles -> oStall=3; accept -> 0. 70000 stall cycles -> oStall=16'hFFFF.
